vram_arbiter: RTL and testbench

Shares one single-port synchronous video RAM between the VGA scanout fetcher and the CPU data-memory port. It sits between the soft RISC-V core, the VGA timing/pixel pipeline and the framebuffer block RAM inside `top`. VGA has priority because it has a hard scanline deadline. A starvation counter guarantees the CPU a slot within a bounded number of cycles.

---
 rtl/vram_arbiter.sv | 115 +++++++++++
 tb/tb_vram_arbiter.sv | 324 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vram_arbiter.sv
// Arbiter sharing one single-port video RAM between VGA scanout (priority) and the CPU.
// A saturating starvation counter forces a CPU slot after STARVE_LIMIT consecutive losses.
module vram_arbiter #(
   parameter int ADDR_W       = 16,
   parameter int DATA_W       = 32,
   parameter int STARVE_LIMIT = 4
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                vga_req,
   input  logic [ADDR_W-1:0]   vga_addr,
   output logic                vga_gnt,
   output logic                vga_rvalid,
   output logic [DATA_W-1:0]   vga_rdata,
   input  logic                cpu_req,
   input  logic                cpu_we,
   input  logic [ADDR_W-1:0]   cpu_addr,
   input  logic [DATA_W-1:0]   cpu_wdata,
   input  logic [DATA_W/8-1:0] cpu_wstrb,
   output logic                cpu_gnt,
   output logic                cpu_rvalid,
   output logic [DATA_W-1:0]   cpu_rdata,
   output logic                mem_en,
   output logic [DATA_W/8-1:0] mem_we,
   output logic [ADDR_W-1:0]   mem_addr,
   output logic [DATA_W-1:0]   mem_wdata,
   input  logic [DATA_W-1:0]   mem_rdata
);

   typedef enum logic {
      ST_NORMAL    = 1'b0,
      ST_FORCE_CPU = 1'b1
   } state_t;

   localparam logic [1:0] OWN_NONE = 2'd0;
   localparam logic [1:0] OWN_VGA  = 2'd1;
   localparam logic [1:0] OWN_CPU  = 2'd2;
   localparam logic [7:0] LIMIT    = 8'(STARVE_LIMIT);

   state_t      state, state_next;
   logic [7:0]  starve_cnt, starve_next;
   logic [1:0]  owner, owner_next;

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= ST_NORMAL;
         starve_cnt <= 8'd0;
         owner      <= OWN_NONE;
      end else begin
         state      <= state_next;
         starve_cnt <= starve_next;
         owner      <= owner_next;
      end
   end

   // Entering FORCE_CPU is decided from the updated count so the CPU wins the very next cycle.
   always_comb begin
      starve_next = starve_cnt;
      state_next  = state;
      owner_next  = OWN_NONE;
      if (cpu_gnt) begin
         starve_next = 8'd0;
      end else if (cpu_req && vga_gnt && (starve_cnt < LIMIT)) begin
         starve_next = starve_cnt + 8'd1;
      end else begin
         starve_next = starve_cnt;
      end
      case (state)
         ST_NORMAL:    state_next = (starve_next >= LIMIT) ? ST_FORCE_CPU : ST_NORMAL;
         ST_FORCE_CPU: state_next = cpu_gnt ? ST_NORMAL : ST_FORCE_CPU;
         default:      state_next = ST_NORMAL;
      endcase
      if (vga_gnt) begin
         owner_next = OWN_VGA;
      end else if (cpu_gnt && !cpu_we) begin
         owner_next = OWN_CPU;
      end else begin
         owner_next = OWN_NONE;
      end
   end

   // Rvalid is gated by rst so a read granted just before reset never returns.
   always_comb begin
      vga_gnt = 1'b0;
      cpu_gnt = 1'b0;
      if (rst) begin
         vga_gnt = 1'b0;
         cpu_gnt = 1'b0;
      end else begin
         case (state)
            ST_NORMAL: begin
               vga_gnt = vga_req;
               cpu_gnt = cpu_req & ~vga_req;
            end
            ST_FORCE_CPU: begin
               cpu_gnt = cpu_req;
               vga_gnt = vga_req & ~cpu_req;
            end
            default: begin
               vga_gnt = 1'b0;
               cpu_gnt = 1'b0;
            end
         endcase
      end
      mem_en     = vga_gnt | cpu_gnt;
      mem_addr   = cpu_gnt ? cpu_addr : vga_addr;
      mem_we     = (cpu_gnt && cpu_we) ? cpu_wstrb : '0;
      mem_wdata  = cpu_wdata;
      vga_rvalid = (owner == OWN_VGA) && !rst;
      cpu_rvalid = (owner == OWN_CPU) && !rst;
      vga_rdata  = vga_rvalid ? mem_rdata : '0;
      cpu_rdata  = cpu_rvalid ? mem_rdata : '0;
   end

endmodule

// File: tb/tb_vram_arbiter.sv
// Self-checking bench for vram_arbiter: directed scenarios plus a randomized run
// compared against a loss-counting reference model and a shadow memory.
module tb_vram_arbiter;

   localparam int ADDR_W = 16;
   localparam int DATA_W = 32;
   localparam int LIMIT  = 4;

   logic              clk = 1'b0;
   logic              rst;
   logic              vga_req;
   logic [ADDR_W-1:0] vga_addr;
   logic              vga_gnt, vga_rvalid;
   logic [DATA_W-1:0] vga_rdata;
   logic              cpu_req, cpu_we;
   logic [ADDR_W-1:0] cpu_addr;
   logic [DATA_W-1:0] cpu_wdata;
   logic [3:0]        cpu_wstrb;
   logic              cpu_gnt, cpu_rvalid;
   logic [DATA_W-1:0] cpu_rdata;
   logic              mem_en;
   logic [3:0]        mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_wdata, mem_rdata;

   logic [31:0] ram [0:255];
   logic [31:0] ref_mem [0:255];
   logic [31:0] ram_q;

   int checks = 0;
   int errors = 0;

   vram_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .STARVE_LIMIT(LIMIT)) dut (
      .clk(clk), .rst(rst),
      .vga_req(vga_req), .vga_addr(vga_addr), .vga_gnt(vga_gnt),
      .vga_rvalid(vga_rvalid), .vga_rdata(vga_rdata),
      .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr),
      .cpu_wdata(cpu_wdata), .cpu_wstrb(cpu_wstrb), .cpu_gnt(cpu_gnt),
      .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
      .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
   );

   always #5 clk = ~clk;

   // Single-port synchronous RAM, read-before-write, one cycle latency
   always @(posedge clk) begin
      if (mem_en) begin
         for (int b = 0; b < 4; b++)
            if (mem_we[b]) ram[mem_addr[7:0]][8*b +: 8] <= mem_wdata[8*b +: 8];
         ram_q <= ram[mem_addr[7:0]];
      end
   end
   assign mem_rdata = ram_q;

   task automatic idle_inputs();
      vga_req = 1'b0; vga_addr = '0;
      cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0; cpu_wstrb = 4'd0;
   endtask

   task automatic apply_reset();
      @(negedge clk);
      rst = 1'b1;
      idle_inputs();
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic test_reset();
      for (int c = 0; c < 2; c++) begin
         @(negedge clk);
         rst = 1'b1; vga_req = 1'b1; cpu_req = 1'b1; vga_addr = 16'h0003; cpu_addr = 16'h0004;
         #1;
         checks++;
         if ({vga_gnt, cpu_gnt, mem_en, mem_we, vga_rvalid, cpu_rvalid} !== 9'd0) begin
            errors++;
            $display("FAIL reset_outputs: got vgnt=%b cgnt=%b en=%b we=%b vrv=%b crv=%b required all 0",
                     vga_gnt, cpu_gnt, mem_en, mem_we, vga_rvalid, cpu_rvalid);
         end
         checks++;
         if ({vga_rdata, cpu_rdata} !== 64'd0) begin
            errors++;
            $display("FAIL reset_rdata: got %h %h required 0", vga_rdata, cpu_rdata);
         end
      end
      @(negedge clk);
      rst = 1'b0;
      #1;
      checks++;
      if (vga_gnt !== 1'b1 || cpu_gnt !== 1'b0) begin
         errors++;
         $display("FAIL post_reset_grant: got vgnt=%b cgnt=%b required 1 0", vga_gnt, cpu_gnt);
      end
      @(negedge clk);
      idle_inputs();
      checks++;
      if (dut.starve_cnt !== 8'd1) begin
         errors++;
         $display("FAIL post_reset_starve: got %0d required 1", dut.starve_cnt);
      end
   endtask

   task automatic test_vga_read();
      apply_reset();
      ram[16] <= 32'hDEADBEEF;
      @(negedge clk);
      vga_req = 1'b1; vga_addr = 16'h0010;
      #1;
      checks++;
      if (vga_gnt !== 1'b1 || mem_en !== 1'b1 || mem_addr !== 16'h0010 || mem_we !== 4'd0) begin
         errors++;
         $display("FAIL vga_grant: got gnt=%b en=%b addr=%h we=%b required 1 1 0010 0000",
                  vga_gnt, mem_en, mem_addr, mem_we);
      end
      @(negedge clk);
      idle_inputs();
      #1;
      checks++;
      if (vga_rvalid !== 1'b1 || vga_rdata !== 32'hDEADBEEF || cpu_rvalid !== 1'b0 || cpu_rdata !== 32'd0) begin
         errors++;
         $display("FAIL vga_read_data: got vrv=%b vd=%h crv=%b cd=%h required 1 deadbeef 0 0",
                  vga_rvalid, vga_rdata, cpu_rvalid, cpu_rdata);
      end
   endtask

   task automatic test_byte_write();
      apply_reset();
      ram[32] <= 32'd0;
      @(negedge clk);
      cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 16'h0020; cpu_wdata = 32'h11223344; cpu_wstrb = 4'b0010;
      #1;
      checks++;
      if (cpu_gnt !== 1'b1 || mem_we !== 4'b0010 || mem_wdata !== 32'h11223344 || mem_addr !== 16'h0020) begin
         errors++;
         $display("FAIL cpu_write_drive: got gnt=%b we=%b wd=%h addr=%h required 1 0010 11223344 0020",
                  cpu_gnt, mem_we, mem_wdata, mem_addr);
      end
      @(negedge clk);
      cpu_we = 1'b0; cpu_wstrb = 4'd0;
      #1;
      checks++;
      if (cpu_rvalid !== 1'b0 || vga_rvalid !== 1'b0) begin
         errors++;
         $display("FAIL write_no_rvalid: got crv=%b vrv=%b required 0 0", cpu_rvalid, vga_rvalid);
      end
      @(negedge clk);
      idle_inputs();
      #1;
      checks++;
      if (cpu_rvalid !== 1'b1 || cpu_rdata !== 32'h00003300) begin
         errors++;
         $display("FAIL byte_write_readback: got crv=%b cd=%h required 1 00003300", cpu_rvalid, cpu_rdata);
      end
   endtask

   task automatic test_starvation();
      apply_reset();
      for (int c = 0; c <= LIMIT + 1; c++) begin
         @(negedge clk);
         vga_req = 1'b1; vga_addr = 16'(c);
         cpu_req = (c <= LIMIT); cpu_addr = 16'h0040;
         #1;
         checks++;
         if (vga_gnt !== (c != LIMIT) || cpu_gnt !== (c == LIMIT)) begin
            errors++;
            $display("FAIL starvation_c%0d: got vgnt=%b cgnt=%b required %b %b",
                     c, vga_gnt, cpu_gnt, c != LIMIT, c == LIMIT);
         end
      end
      @(negedge clk);
      idle_inputs();
   endtask

   task automatic test_interleaved();
      apply_reset();
      ram[1] <= 32'hA1A1_0001;
      ram[2] <= 32'hB2B2_0002;
      @(negedge clk);
      vga_req = 1'b1; vga_addr = 16'h0001;
      @(negedge clk);
      vga_req = 1'b0; cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h0002;
      #1;
      checks++;
      if (cpu_gnt !== 1'b1 || vga_rvalid !== 1'b1 || vga_rdata !== 32'hA1A1_0001 || cpu_rvalid !== 1'b0) begin
         errors++;
         $display("FAIL interleave_c1: got cgnt=%b vrv=%b vd=%h crv=%b required 1 1 a1a10001 0",
                  cpu_gnt, vga_rvalid, vga_rdata, cpu_rvalid);
      end
      @(negedge clk);
      idle_inputs();
      #1;
      checks++;
      if (cpu_rvalid !== 1'b1 || cpu_rdata !== 32'hB2B2_0002 || vga_rvalid !== 1'b0 || vga_rdata !== 32'd0) begin
         errors++;
         $display("FAIL interleave_c2: got crv=%b cd=%h vrv=%b vd=%h required 1 b2b20002 0 0",
                  cpu_rvalid, cpu_rdata, vga_rvalid, vga_rdata);
      end
   endtask

   task automatic test_reset_mid_read();
      apply_reset();
      ram[5] <= 32'h0000_55AA;
      @(negedge clk);
      cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h0005;
      #1;
      checks++;
      if (cpu_gnt !== 1'b1) begin
         errors++;
         $display("FAIL midread_grant: got %b required 1", cpu_gnt);
      end
      @(negedge clk);
      idle_inputs();
      rst = 1'b1;
      #1;
      checks++;
      if (cpu_rvalid !== 1'b0 || cpu_rdata !== 32'd0) begin
         errors++;
         $display("FAIL midread_rst_cycle: got crv=%b cd=%h required 0 0", cpu_rvalid, cpu_rdata);
      end
      for (int c = 0; c < 2; c++) begin
         @(negedge clk);
         rst = 1'b0;
         #1;
         checks++;
         if (cpu_rvalid !== 1'b0 || vga_rvalid !== 1'b0) begin
            errors++;
            $display("FAIL midread_after_%0d: got crv=%b vrv=%b required 0 0", c, cpu_rvalid, vga_rvalid);
         end
      end
   endtask

   // Model: CPU wins when VGA is idle or it has already lost LIMIT requesting cycles
   task automatic test_random();
      int          losses = 0;
      bit          vga_pend = 0, cpu_pend = 0;
      bit          exp_cpu, exp_vga;
      int          prev_owner = 0;
      logic [31:0] prev_data = '0;
      int          next_owner;
      logic [31:0] next_data, v;
      logic [3:0]  exp_we;
      apply_reset();
      for (int i = 0; i < 64; i++) begin
         v = $urandom;
         ram[i] <= v;
         ref_mem[i] = v;
      end
      for (int cyc = 0; cyc < 400; cyc++) begin
         @(negedge clk);
         if (!vga_pend && ($urandom_range(0, 9) < 7)) begin
            vga_pend = 1; vga_addr = 16'($urandom_range(0, 63));
         end
         if (!cpu_pend && ($urandom_range(0, 9) < 5)) begin
            cpu_pend = 1; cpu_addr = 16'($urandom_range(0, 63));
            cpu_we = 1'($urandom_range(0, 1)); cpu_wdata = $urandom; cpu_wstrb = 4'($urandom_range(0, 15));
         end
         vga_req = vga_pend;
         cpu_req = cpu_pend;
         #1;
         exp_cpu = cpu_pend && (!vga_pend || losses >= LIMIT);
         exp_vga = vga_pend && !exp_cpu;
         exp_we  = (exp_cpu && cpu_we) ? cpu_wstrb : 4'd0;
         checks++;
         if (vga_gnt !== exp_vga || cpu_gnt !== exp_cpu || mem_en !== (exp_vga || exp_cpu) || mem_we !== exp_we) begin
            errors++;
            $display("FAIL rand_grant cyc%0d: got vg=%b cg=%b en=%b we=%b required %b %b %b %b",
                     cyc, vga_gnt, cpu_gnt, mem_en, mem_we, exp_vga, exp_cpu, exp_vga || exp_cpu, exp_we);
         end
         if (exp_vga || exp_cpu) begin
            checks++;
            if (mem_addr !== (exp_cpu ? cpu_addr : vga_addr)) begin
               errors++;
               $display("FAIL rand_addr cyc%0d: got %h required %h", cyc, mem_addr, exp_cpu ? cpu_addr : vga_addr);
            end
         end
         checks++;
         if (vga_rvalid !== (prev_owner == 1) || cpu_rvalid !== (prev_owner == 2) ||
             vga_rdata !== ((prev_owner == 1) ? prev_data : 32'd0) ||
             cpu_rdata !== ((prev_owner == 2) ? prev_data : 32'd0)) begin
            errors++;
            $display("FAIL rand_read cyc%0d: got vrv=%b vd=%h crv=%b cd=%h required owner=%0d data=%h",
                     cyc, vga_rvalid, vga_rdata, cpu_rvalid, cpu_rdata, prev_owner, prev_data);
         end
         next_owner = 0;
         next_data  = '0;
         if (exp_cpu) begin
            losses = 0;
            cpu_pend = 0;
            if (!cpu_we) begin
               next_owner = 2;
               next_data  = ref_mem[cpu_addr[7:0]];
            end else begin
               for (int b = 0; b < 4; b++)
                  if (cpu_wstrb[b]) ref_mem[cpu_addr[7:0]][8*b +: 8] = cpu_wdata[8*b +: 8];
            end
         end
         if (exp_vga) begin
            if (cpu_pend && losses < LIMIT) losses++;
            vga_pend = 0;
            next_owner = 1;
            next_data  = ref_mem[vga_addr[7:0]];
         end
         prev_owner = next_owner;
         prev_data  = next_data;
      end
      @(negedge clk);
      idle_inputs();
   endtask

   initial begin
      rst = 1'b1;
      idle_inputs();
      test_reset();
      test_vga_read();
      test_byte_write();
      test_starvation();
      test_interleaved();
      test_reset_mid_read();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
